// File: rtl/vjtag_reg_bridge.sv
// Virtual JTAG data-register engine: decodes the hub's virtual instruction,
// runs capture/shift/update on a shared shift register and acts as a simple
// register-bus master in the tck domain. tck is the only clock.
module vjtag_reg_bridge #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] ID_VALUE = 32'h4A544147,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [9:0]        ir_in,
    output logic [9:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata
);

    // Shift register must hold the widest of IDCODE, address and data.
    localparam int AD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAXW   = (AD_MAX > 32) ? AD_MAX : 32;
    localparam int LEN_W  = $clog2(MAXW + 1);

    localparam logic [9:0] IR_BYPASS = 10'h000;
    localparam logic [9:0] IR_IDCODE = 10'h001;
    localparam logic [9:0] IR_ADDR   = 10'h002;
    localparam logic [9:0] IR_WRITE  = 10'h003;
    localparam logic [9:0] IR_READ   = 10'h004;
    localparam logic [9:0] IR_CLRERR = 10'h3FF;

    localparam logic [2:0] OP_BYPASS  = 3'd0;
    localparam logic [2:0] OP_IDCODE  = 3'd1;
    localparam logic [2:0] OP_ADDR    = 3'd2;
    localparam logic [2:0] OP_WRITE   = 3'd3;
    localparam logic [2:0] OP_READ    = 3'd4;
    localparam logic [2:0] OP_CLRERR  = 3'd5;
    localparam logic [2:0] OP_UNKNOWN = 3'd6;

    logic [MAXW-1:0]   sr_r;
    logic [ADDR_W-1:0] reg_addr_r;
    logic [DATA_W-1:0] reg_wdata_r;
    logic              reg_wr_r;
    logic              reg_rd_r;
    logic              err_r;
    logic [9:0]        ir_out_r;

    logic [2:0]        op_s;
    logic [LEN_W-1:0]  dr_len_s;
    logic [MAXW-1:0]   cap_s;
    logic [MAXW-1:0]   sr_shr_s;
    logic [MAXW-1:0]   shift_s;
    logic [MAXW-1:0]   addr_ext_s;
    logic [7:0]        addr8_s;
    logic              unused_s;

    // Exit states and the upper address bits carry no function here.
    assign unused_s = ^{virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr,
                        addr_ext_s[MAXW-1:8]};

    assign addr_ext_s = MAXW'(reg_addr_r);
    assign addr8_s    = addr_ext_s[7:0];
    assign sr_shr_s   = {1'b0, sr_r[MAXW-1:1]};

    // Decode the full 10-bit instruction into an operation and its DR length.
    always_comb begin
        op_s     = OP_UNKNOWN;
        dr_len_s = LEN_W'(1);
        case (ir_in)
            IR_BYPASS: op_s = OP_BYPASS;
            IR_IDCODE: op_s = OP_IDCODE;
            IR_ADDR:   op_s = OP_ADDR;
            IR_WRITE:  op_s = OP_WRITE;
            IR_READ:   op_s = OP_READ;
            IR_CLRERR: op_s = OP_CLRERR;
            default:   op_s = OP_UNKNOWN;
        endcase
        case (op_s)
            OP_IDCODE: dr_len_s = LEN_W'(32);
            OP_ADDR:   dr_len_s = LEN_W'(ADDR_W);
            OP_WRITE:  dr_len_s = LEN_W'(DATA_W);
            OP_READ:   dr_len_s = LEN_W'(DATA_W);
            default:   dr_len_s = LEN_W'(1);
        endcase
    end

    // Value loaded into the shift register on capture-DR.
    always_comb begin
        cap_s = {MAXW{1'b0}};
        case (op_s)
            OP_IDCODE: cap_s = MAXW'(ID_VALUE);
            OP_ADDR:   cap_s = addr_ext_s;
            OP_READ:   cap_s = MAXW'(reg_rdata);
            default:   cap_s = {MAXW{1'b0}};
        endcase
    end

    // Next shift-register value for one shift-DR: only the low L bits move.
    always_comb begin
        shift_s = sr_r;
        for (int i = 0; i < MAXW; i++) begin
            if (i < int'(dr_len_s) - 1) begin
                shift_s[i] = sr_shr_s[i];
            end else if (i == int'(dr_len_s) - 1) begin
                shift_s[i] = tdi;
            end else begin
                shift_s[i] = sr_r[i];
            end
        end
    end

    // TAP-state engine; one strobe acted on per cycle, CDR>SDR>UDR>CIR>UIR.
    always_ff @(posedge tck) begin
        if (!rst_n) begin
            sr_r        <= {MAXW{1'b0}};
            reg_addr_r  <= {ADDR_W{1'b0}};
            reg_wdata_r <= {DATA_W{1'b0}};
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            err_r       <= 1'b0;
            ir_out_r    <= 10'h000;
        end else begin
            reg_wr_r <= 1'b0;
            reg_rd_r <= 1'b0;
            // Write increment lands one cycle after the strobe so the slave
            // sees the pre-increment address alongside reg_wr.
            if (reg_wr_r && AUTO_INC) begin
                reg_addr_r <= reg_addr_r + ADDR_W'(1);
            end
            if (virtual_state_cdr) begin
                sr_r <= cap_s;
                if (op_s == OP_READ) begin
                    reg_rd_r <= ~reg_rd_r;
                end
            end else if (virtual_state_sdr) begin
                sr_r <= shift_s;
            end else if (virtual_state_udr) begin
                case (op_s)
                    OP_ADDR: begin
                        reg_addr_r <= sr_r[ADDR_W-1:0];
                    end
                    OP_WRITE: begin
                        reg_wdata_r <= sr_r[DATA_W-1:0];
                        reg_wr_r    <= ~reg_wr_r;
                    end
                    OP_READ: begin
                        if (AUTO_INC) begin
                            reg_addr_r <= reg_addr_r + ADDR_W'(1);
                        end
                    end
                    OP_UNKNOWN: begin
                        err_r <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (virtual_state_cir) begin
                ir_out_r <= {addr8_s, 1'b0, err_r};
            end else if (virtual_state_uir) begin
                if (ir_in == IR_CLRERR) begin
                    err_r <= 1'b0;
                end
            end
        end
    end

    assign tdo       = sr_r[0];
    assign ir_out    = ir_out_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;

endmodule

// File: tb/tb_vjtag_reg_bridge.sv
// Directed bench for vjtag_reg_bridge: a table of DR scans with hand-computed
// results, then hand-written error-flag and reset-abort sequences. A second
// instance with AUTO_INC=0 rides along on the same stimulus.
module tb_vjtag_reg_bridge;

    logic        tck = 1'b0;
    logic        rst_n = 1'b0;
    logic        tdi = 1'b0;
    logic [9:0]  ir_in = 10'h000;
    logic        cdr = 1'b0, sdr = 1'b0, e1dr = 1'b0, pdr = 1'b0;
    logic        e2dr = 1'b0, udr = 1'b0, cir = 1'b0, uir = 1'b0;

    logic        tdo, tdo_ni;
    logic [9:0]  ir_out, ir_out_ni;
    logic [15:0] reg_addr, reg_addr_ni;
    logic [31:0] reg_wdata, reg_wdata_ni, reg_rdata, reg_rdata_ni;
    logic        reg_wr, reg_rd, reg_wr_ni, reg_rd_ni;

    // Register-slave model: read data is address + 0x100.
    assign reg_rdata    = {16'h0000, reg_addr + 16'h0100};
    assign reg_rdata_ni = {16'h0000, reg_addr_ni + 16'h0100};

    vjtag_reg_bridge #(.ADDR_W(16), .DATA_W(32), .ID_VALUE(32'h4A544147), .AUTO_INC(1'b1)) dut (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata)
    );

    vjtag_reg_bridge #(.ADDR_W(16), .DATA_W(32), .ID_VALUE(32'h4A544147), .AUTO_INC(1'b0)) dut_ni (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo_ni), .ir_in(ir_in), .ir_out(ir_out_ni),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .reg_addr(reg_addr_ni), .reg_wdata(reg_wdata_ni), .reg_wr(reg_wr_ni), .reg_rd(reg_rd_ni),
        .reg_rdata(reg_rdata_ni)
    );

    always #5 tck = ~tck;

    int tests = 0;
    int failed = 0;

    // Strobe monitor (main instance), sampled on the falling edge.
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, consec_cnt = 0;
    logic        prev_wr = 1'b0, prev_rd = 1'b0;
    logic [15:0] wr_addr_seen = 16'h0, addr_after_wr = 16'h0;
    logic [31:0] wr_data_seen = 32'h0;

    always @(negedge tck) begin
        if (reg_wr) begin
            wr_cnt       = wr_cnt + 1;
            wr_addr_seen = reg_addr;
            wr_data_seen = reg_wdata;
        end
        if (prev_wr) addr_after_wr = reg_addr;
        if (reg_rd) rd_cnt = rd_cnt + 1;
        if (reg_wr && reg_rd) both_cnt = both_cnt + 1;
        if ((reg_wr && prev_wr) || (reg_rd && prev_rd)) consec_cnt = consec_cnt + 1;
        prev_wr = reg_wr;
        prev_rd = reg_rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full DR scan; starts and ends just after a falling edge.
    task automatic dr_scan(input logic [9:0] ir, input logic [31:0] din, input int len,
                           input bit upd, output logic [31:0] dout);
        dout  = 32'h0;
        ir_in = ir;
        cdr   = 1'b1;
        @(negedge tck);
        cdr = 1'b0;
        for (int k = 0; k < len; k++) begin
            dout[k] = tdo;
            tdi     = din[k];
            sdr     = 1'b1;
            @(negedge tck);
        end
        sdr  = 1'b0;
        e1dr = 1'b1;
        @(negedge tck);
        e1dr = 1'b0;
        if (upd) begin
            udr = 1'b1;
            @(negedge tck);
            udr = 1'b0;
        end
        @(negedge tck);
        @(negedge tck);
    endtask

    task automatic pulse_ir(input logic [9:0] ir, input bit do_cir, input bit do_uir, input bit do_udr);
        ir_in = ir;
        cir   = do_cir;
        uir   = do_uir;
        udr   = do_udr;
        @(negedge tck);
        cir = 1'b0;
        uir = 1'b0;
        udr = 1'b0;
        @(negedge tck);
    endtask

    typedef struct {
        logic [9:0]  ir;
        logic [31:0] din;
        int          len;
        bit          upd;
        logic [31:0] exp_dout;
        int          exp_wr;
        int          exp_rd;
        logic [15:0] exp_wr_addr;
        logic [31:0] exp_wdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_addr_ni;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] dout, mask;
        int          wr0, rd0;

        vecs[0] = '{10'h001, 32'h00000000, 32, 1'b1, 32'h4A544147, 0, 0, 16'h0000, 32'h00000000, 16'h0000, 16'h0000};
        vecs[1] = '{10'h002, 32'h00001234, 16, 1'b1, 32'h00000000, 0, 0, 16'h0000, 32'h00000000, 16'h1234, 16'h1234};
        vecs[2] = '{10'h003, 32'hDEADBEEF, 32, 1'b1, 32'h00000000, 1, 0, 16'h1234, 32'hDEADBEEF, 16'h1235, 16'h1234};
        vecs[3] = '{10'h002, 32'h00000010, 16, 1'b1, 32'h00001235, 0, 0, 16'h0000, 32'h00000000, 16'h0010, 16'h0010};
        vecs[4] = '{10'h004, 32'h00000000, 32, 1'b1, 32'h00000110, 0, 1, 16'h0000, 32'h00000000, 16'h0011, 16'h0010};
        vecs[5] = '{10'h004, 32'h00000000, 32, 1'b1, 32'h00000111, 0, 1, 16'h0000, 32'h00000000, 16'h0012, 16'h0010};
        vecs[6] = '{10'h002, 32'h0000FFFF, 16, 1'b1, 32'h00000012, 0, 0, 16'h0000, 32'h00000000, 16'hFFFF, 16'hFFFF};
        vecs[7] = '{10'h003, 32'h0000A5A5, 32, 1'b1, 32'h00000000, 1, 0, 16'hFFFF, 32'h0000A5A5, 16'h0000, 16'hFFFF};
        vecs[8] = '{10'h000, 32'h00000001, 1,  1'b1, 32'h00000000, 0, 0, 16'h0000, 32'h00000000, 16'h0000, 16'hFFFF};
        vecs[9] = '{10'h002, 32'h0000ABCD, 16, 1'b0, 32'h00000000, 0, 0, 16'h0000, 32'h00000000, 16'h0000, 16'hFFFF};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge tck);
        check("rst_addr",  {16'h0, reg_addr}, 32'h0);
        check("rst_wdata", reg_wdata, 32'h0);
        check("rst_wr_rd", {30'h0, reg_wr, reg_rd}, 32'h0);
        check("rst_irout", {22'h0, ir_out}, 32'h0);
        check("rst_tdo",   {31'h0, tdo}, 32'h0);
        rst_n = 1'b1;
        @(negedge tck);

        // Table of DR scans
        for (int v = 0; v < 10; v++) begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            dr_scan(vecs[v].ir, vecs[v].din, vecs[v].len, vecs[v].upd, dout);
            mask = (vecs[v].len >= 32) ? 32'hFFFFFFFF : ((32'h1 << vecs[v].len) - 32'h1);
            check($sformatf("v%0d_tdo", v), dout & mask, vecs[v].exp_dout);
            check($sformatf("v%0d_wr_cnt", v), 32'(wr_cnt - wr0), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d_rd_cnt", v), 32'(rd_cnt - rd0), 32'(vecs[v].exp_rd));
            check($sformatf("v%0d_addr", v), {16'h0, reg_addr}, {16'h0, vecs[v].exp_addr});
            check($sformatf("v%0d_addr_noinc", v), {16'h0, reg_addr_ni}, {16'h0, vecs[v].exp_addr_ni});
            if (vecs[v].exp_wr != 0) begin
                check($sformatf("v%0d_wr_addr", v), {16'h0, wr_addr_seen}, {16'h0, vecs[v].exp_wr_addr});
                check($sformatf("v%0d_wdata", v), wr_data_seen, vecs[v].exp_wdata);
                check($sformatf("v%0d_addr_next", v), {16'h0, addr_after_wr}, {16'h0, vecs[v].exp_addr});
            end
        end

        // Error flag: set by unknown-instruction update, cleared by CLRERR on UIR
        pulse_ir(10'h000, 1'b1, 1'b0, 1'b0);
        check("irout_noerr",    {22'h0, ir_out},    32'h000);
        check("irout_noerr_ni", {22'h0, ir_out_ni}, 32'h3FC);
        pulse_ir(10'h155, 1'b0, 1'b0, 1'b1);
        pulse_ir(10'h155, 1'b1, 1'b0, 1'b0);
        check("irout_err",    {22'h0, ir_out},    32'h001);
        check("irout_err_ni", {22'h0, ir_out_ni}, 32'h3FD);
        pulse_ir(10'h3FF, 1'b0, 1'b1, 1'b0);
        pulse_ir(10'h3FF, 1'b1, 1'b0, 1'b0);
        check("irout_clr",    {22'h0, ir_out},    32'h000);
        check("irout_clr_ni", {22'h0, ir_out_ni}, 32'h3FC);

        // Reset mid-shift aborts a WRITE scan, even with UDR in the reset cycle
        dr_scan(10'h002, 32'h00000055, 16, 1'b1, dout);
        check("pre_rst_addr", {16'h0, reg_addr}, 32'h0055);
        wr0   = wr_cnt;
        ir_in = 10'h003;
        cdr   = 1'b1;
        @(negedge tck);
        cdr = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tdi = k[0];
            sdr = 1'b1;
            @(negedge tck);
        end
        sdr   = 1'b0;
        udr   = 1'b1;
        rst_n = 1'b0;
        @(negedge tck);
        udr   = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge tck);
        check("abort_wr_cnt", 32'(wr_cnt - wr0), 32'h0);
        check("abort_wdata",  reg_wdata, 32'h0);
        check("abort_addr",   {16'h0, reg_addr}, 32'h0);
        check("abort_addr_ni", {16'h0, reg_addr_ni}, 32'h0);
        check("abort_irout_ni", {22'h0, ir_out_ni}, 32'h0);

        // Strobe hygiene over the whole run
        check("wr_rd_both", 32'(both_cnt), 32'h0);
        check("strobe_consecutive", 32'(consec_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1);
    end

endmodule
